rx_wr_space_tracker: RTL and testbench

- Write-side space tracker for the RX ring buffer.
- Consumes the committed read address after it has crossed into the write clock domain, and owns the committed write pointer.
- Arbitrates frame-space reservations from the RX frame writer: grant, hold or drop.
- Publishes the committed write address and the free space. The block is single-clock and sits directly downstream of the read-address synchroniser.

---
 rtl/rx_wr_space_tracker_pkg.sv | 18 +
 rtl/rx_free_space_calc.sv | 39 +++
 rtl/rx_wr_space_tracker.sv | 110 +++++++++++
 tb/tb_rx_wr_space_tracker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_wr_space_tracker_pkg.sv
// Shared definitions for the RX ring write-side space tracker: FSM encodings
// and the ring address-width macro used by the surrounding codebase.
`ifndef BF
`define BF 9
`endif

package rx_wr_space_tracker_pkg;

  // One-hot encodings keep the state decode to a single flop per state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_CHECK = 3'b010,
    ST_BUSY  = 3'b100
  } state_e;

  localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/rx_free_space_calc.sv
// Registers the synchronised read pointer and derives the registered free
// word count and almost_full flag from it and the committed write pointer.
module rx_free_space_calc #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned ALMOST_FULL_TH = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  output logic [ADDR_W-1:0] free_space,
  output logic              almost_full
);

  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] free_d;
  logic              af_d;

  // One slot always stays empty so rd == wr reads as an empty ring.
  always_comb begin
    free_d = rd_q - wr_addr_in - ADDR_W'(1);
    af_d   = (32'(free_d) < ALMOST_FULL_TH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q        <= '0;
      free_space  <= '0;
      almost_full <= 1'b0;
    end else begin
      rd_q        <= rd_addr_in;
      free_space  <= free_d;
      almost_full <= af_d;
    end
  end

endmodule

// File: rtl/rx_wr_space_tracker.sv
// Write-side space tracker: arbitrates frame reservations against the
// registered free space and owns the committed write pointer.
module rx_wr_space_tracker
  import rx_wr_space_tracker_pkg::*;
#(
  parameter int unsigned ADDR_W         = `BF + 1,
  parameter int unsigned ALMOST_FULL_TH = 64,
  parameter int unsigned WAIT_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] commited_rd_address_in,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_len,
  output logic              req_grant,
  output logic              req_reject,
  output logic              req_drop,
  input  logic              wr_done,
  input  logic              wr_abort,
  output logic [ADDR_W-1:0] wr_base_address,
  output logic [ADDR_W-1:0] commited_wr_address,
  output logic [ADDR_W-1:0] free_space,
  output logic              almost_full,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_TIMEOUT);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]     wr_q, wr_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;

  rx_free_space_calc #(
    .ADDR_W         (ADDR_W),
    .ALMOST_FULL_TH (ALMOST_FULL_TH)
  ) u_free_space_calc (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr_in  (commited_rd_address_in),
    .wr_addr_in  (wr_q),
    .free_space  (free_space),
    .almost_full (almost_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_d       = wr_q;
    wait_d     = wait_q;
    req_grant  = 1'b0;
    req_reject = 1'b0;
    req_drop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          len_d   = req_len;
          wait_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // An ADDR_W-bit length never exceeds the ring's maximum free space,
        // so zero is the only length that can never fit.
        if (len_q == '0) begin
          req_reject = 1'b1;
          state_d    = ST_IDLE;
        end else if (len_q <= free_space) begin
          req_grant = 1'b1;
          state_d   = ST_BUSY;
        end else if (wait_q == WAIT_LIMIT) begin
          req_drop = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (wr_done) begin
          wr_d    = wr_q + len_q;
          state_d = ST_IDLE;
        end else if (wr_abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy                = (state_q == ST_BUSY);
  assign commited_wr_address = wr_q;
  assign wr_base_address     = wr_q;

endmodule

// File: tb/tb_rx_wr_space_tracker.sv
// Scoreboard bench for rx_wr_space_tracker: the driver predicts each request's
// outcome from ring arithmetic; a monitor checks the pulses as they appear.
module tb_rx_wr_space_tracker;

  localparam int unsigned AW    = 4;
  localparam int unsigned TH    = 4;
  localparam int unsigned TO    = 5;
  localparam int          DEPTH = 16;

  typedef enum int {K_GRANT = 0, K_REJECT = 1, K_DROP = 2} kind_e;
  typedef struct {
    kind_e kind;
    int    lat;
    int    base;
    int    issue;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] rd_in = '0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_len = '0;
  logic          req_grant, req_reject, req_drop;
  logic          wr_done = 1'b0;
  logic          wr_abort = 1'b0;
  logic [AW-1:0] wr_base_address, commited_wr_address, free_space;
  logic          almost_full, busy;

  rx_wr_space_tracker #(
    .ADDR_W         (AW),
    .ALMOST_FULL_TH (TH),
    .WAIT_TIMEOUT   (TO)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .commited_rd_address_in (rd_in),
    .req_valid              (req_valid),
    .req_len                (req_len),
    .req_grant              (req_grant),
    .req_reject             (req_reject),
    .req_drop               (req_drop),
    .wr_done                (wr_done),
    .wr_abort               (wr_abort),
    .wr_base_address        (wr_base_address),
    .commited_wr_address    (commited_wr_address),
    .free_space             (free_space),
    .almost_full            (almost_full),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   m_rd = 0;
  int   m_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int free_of(input int rd, input int wr);
    return (rd - wr - 1) & (DEPTH - 1);
  endfunction

  // Reference: the request retries once per cycle against the free space seen
  // that cycle; a read-pointer change driven in cycle 'off' is seen two cycles on.
  function automatic exp_t predict(input int len, input int f_old, input int f_new, input int off);
    exp_t r;
    r.base  = 0;
    r.issue = 0;
    r.kind  = K_DROP;
    r.lat   = TO + 1;
    if (len == 0) begin
      r.kind = K_REJECT;
      r.lat  = 1;
      return r;
    end
    for (int k = 1; k <= TO + 1; k++) begin
      int f;
      f = (off != 0 && k >= off + 2) ? f_new : f_old;
      if (len <= f) begin
        r.kind = K_GRANT;
        r.lat  = k;
        return r;
      end
    end
    return r;
  endfunction

  // Monitor: pops one expectation per pulse.
  initial begin
    exp_t e;
    int   act_kind;
    forever begin
      @(negedge clk);
      if (req_grant || req_reject || req_drop) begin
        check("pulse_onehot", 32'(req_grant) + 32'(req_reject) + 32'(req_drop), 1);
        act_kind = req_grant ? int'(K_GRANT) : (req_reject ? int'(K_REJECT) : int'(K_DROP));
        if (sb.size() == 0) begin
          check("unexpected_pulse", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", act_kind, int'(e.kind));
          check("pulse_latency", cyc - e.issue, e.lat);
          if (e.kind == K_GRANT) check("wr_base_address", wr_base_address, e.base);
        end
      end
    end
  end

  task automatic settle_check(input string tag);
    int f;
    @(negedge clk);
    f = free_of(m_rd, m_wr);
    check({tag, "_wr_addr"}, commited_wr_address, m_wr);
    check({tag, "_free"}, free_space, f);
    check({tag, "_almost_full"}, almost_full, (f < int'(TH)) ? 1 : 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic set_rd(input int v);
    @(posedge clk); #1;
    rd_in = AW'(v);
    m_rd  = v & (DEPTH - 1);
    repeat (2) @(posedge clk);
    settle_check("rd");
  endtask

  task automatic check_all_zero();
    check("rst_grant", req_grant, 0);
    check("rst_reject", req_reject, 0);
    check("rst_drop", req_drop, 0);
    check("rst_busy", busy, 0);
    check("rst_base", wr_base_address, 0);
    check("rst_wr_addr", commited_wr_address, 0);
    check("rst_free", free_space, 0);
    check("rst_almost_full", almost_full, 0);
  endtask

  // action: 0 done, 1 abort, 2 done+abort, 3 reset while busy
  task automatic do_req(input int len, input int action, input int off, input int rd_new);
    exp_t e;
    int   got, was_grant;
    @(posedge clk); #1;
    e       = predict(len, free_of(m_rd, m_wr), free_of(rd_new, m_wr), off);
    e.issue = cyc;
    e.base  = m_wr;
    sb.push_back(e);
    req_valid = 1'b1;
    req_len   = AW'(len);
    got       = 0;
    was_grant = 0;
    for (int k = 1; k <= 12 && got == 0; k++) begin
      @(posedge clk); #1;
      if (k == off) begin
        rd_in = AW'(rd_new);
        m_rd  = rd_new & (DEPTH - 1);
      end
      @(negedge clk);
      got       = (req_grant || req_reject || req_drop) ? 1 : 0;
      was_grant = req_grant ? 1 : 0;
    end
    check("pulse_seen", got, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (was_grant != 0) begin
      check("busy_after_grant", busy, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (action == 3) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero();
        m_wr  = 0;
        m_rd  = 0;
        rd_in = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("release_free", free_space, 0);
        settle_check("post_reset");
        return;
      end
      wr_done  = (action != 1);
      wr_abort = (action != 0);
      @(posedge clk); #1;
      wr_done  = 1'b0;
      wr_abort = 1'b0;
      if (action != 1) m_wr = (m_wr + len) & (DEPTH - 1);
      @(posedge clk);
      settle_check("close");
    end else begin
      repeat (2) @(posedge clk);
      settle_check("end_req");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int used, len, act, off, rdn;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset_free", free_space, 0);
    check("in_reset_busy", busy, 0);
    check("in_reset_wr_addr", commited_wr_address, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("release_free", free_space, 0);
    settle_check("reset");

    // Directed: basic grant, wrap-around, waiting grant, timeout, reject,
    // done+abort together, reset while busy.
    do_req(6, 0, 0, 0);
    set_rd(6);
    do_req(8, 0, 0, 0);
    set_rd(14);
    do_req(5, 0, 0, 0);
    set_rd(7);
    do_req(8, 1, 1, 13);
    do_req(12, 1, 0, 0);
    do_req(0, 0, 0, 0);
    do_req(3, 2, 0, 0);
    do_req(4, 3, 0, 0);
    do_req(5, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      used = (m_wr - m_rd) & (DEPTH - 1);
      if ($urandom_range(0, 1) == 1) set_rd(m_rd + int'($urandom_range(0, used)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        wr_done  = 1'b1;
        wr_abort = $urandom_range(0, 1) == 1;
        @(posedge clk); #1;
        wr_done  = 1'b0;
        wr_abort = 1'b0;
        settle_check("idle_done");
      end
      used = (m_wr - m_rd) & (DEPTH - 1);
      len  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      act  = int'($urandom_range(0, 2));
      off  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      rdn  = (m_rd + int'($urandom_range(0, used))) & (DEPTH - 1);
      do_req(len, act, off, rdn);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
